spi_rd_sched: RTL

Two-port read scheduler in front of the single-lane (x1) SPI flash read engine. Shares the engine between two requesters with round-robin arbitration. Splits each multi-byte read into one single-byte engine transaction per byte, auto-incrementing the address. Returns the bytes to the owning requester.

---
 rtl/spi_rd_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/spi_rd_sched.sv
// Two-port round-robin read scheduler that splits multi-byte reads into single-byte SPI engine transactions.
// Optional per-byte WAIT timeout abort is enabled with `define SPI_SCHED_TIMEOUT_EN.
module spi_rd_sched #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [15:0]        req_cmd,
  input  logic [47:0]        req_addr,
  input  logic [5:0]         req_dummy,
  input  logic [2*LEN_W-1:0] req_len,
  output logic [1:0]         rsp_valid,
  output logic [7:0]         rsp_data,
  output logic               rsp_last,
  output logic               rsp_err,
  output logic               eng_start,
  output logic [7:0]         eng_cmd,
  output logic [23:0]        eng_addr,
  output logic [2:0]         eng_dummy,
  input  logic               eng_finish,
  input  logic [7:0]         eng_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state;
  logic             ptr;
  logic             owner;
  logic [LEN_W-1:0] cnt;
  logic             grant_any;
  logic             grant_id;
  logic [LEN_W-1:0] len_sel;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    case (req_valid)
      2'b01:   begin grant_any = 1'b1; grant_id = 1'b0; end
      2'b10:   begin grant_any = 1'b1; grant_id = 1'b1; end
      2'b11:   begin grant_any = 1'b1; grant_id = ~ptr; end
      default: ;
    endcase
  end

  // Ready is an in-cycle handshake with the IDLE grant; gated so it reads 0 while in reset.
  assign req_ready = (rst_n && state == IDLE && grant_any) ?
                     (grant_id ? 2'b10 : 2'b01) : 2'b00;

  assign len_sel = grant_id ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] tcnt;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT == 0);
  assign rsp_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b1;
      owner     <= 1'b0;
      cnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      eng_start <= 1'b0;
      eng_cmd   <= '0;
      eng_addr  <= '0;
      eng_dummy <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
      rsp_err   <= 1'b0;
      tcnt      <= '0;
`endif
    end else begin
      eng_start <= 1'b0;
      rsp_valid <= '0;
      rsp_last  <= 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
      rsp_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant_any) begin
            ptr       <= grant_id;
            owner     <= grant_id;
            eng_cmd   <= grant_id ? req_cmd[15:8]    : req_cmd[7:0];
            eng_addr  <= grant_id ? req_addr[47:24]  : req_addr[23:0];
            eng_dummy <= grant_id ? req_dummy[5:3]   : req_dummy[2:0];
            cnt       <= (len_sel == '0) ? LEN_W'(1) : len_sel;
            eng_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef SPI_SCHED_TIMEOUT_EN
          tcnt  <= '0;
`endif
        end
        WAIT: begin
          if (eng_finish) begin
            rsp_valid <= owner ? 2'b10 : 2'b01;
            rsp_data  <= eng_data;
            if (cnt == LEN_W'(1)) begin
              rsp_last <= 1'b1;
              cnt      <= '0;
              state    <= IDLE;
            end else begin
              cnt       <= cnt - LEN_W'(1);
              eng_addr  <= eng_addr + 24'd1;
              eng_start <= 1'b1;
              state     <= ISSUE;
            end
          end
`ifdef SPI_SCHED_TIMEOUT_EN
          // A finish arriving in the expiry cycle takes the branch above instead.
          else if (tcnt == TW'(TIMEOUT - 1)) begin
            rsp_valid <= owner ? 2'b10 : 2'b01;
            rsp_data  <= '0;
            rsp_last  <= 1'b1;
            rsp_err   <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
